spike_rate_decoder: RTL
=======================

// Module: spike_rate_decoder
// PURPOSE
//  Rate-decodes spike trains (e.g. LIF neuron i_out lines) back into a 16-bit value.
//  It is the inverse of bitstream_converter: counts spikes over a fixed window of
//  enabled cycles and scales the count to a 0..0xFFFF estimate.
//  It sits after the reservoir and before the readout and error stage.
//  The result is offered through a 1-deep valid/ready output buffer.
// PARAMETERS
//  N_CH      1   number of spike input lines summed per cycle
//  WINDOW    32  enabled cycles per window; WINDOW*N_CH must be a power of two, <=65536
//  OUT_W     16  output data width
//  ALPHA_SH  2   EMA shift, used only when SPIKE_DEC_SMOOTH_EN is defined (1..8)
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous active-low reset
//  enable       in   1      count/advance window only while 1
//  clear        in   1      sync clear of window, count, buffer and overrun
//  spike_in     in   N_CH   spike lines, 1 = spike this cycle
//  out_valid    out  1      out_data holds an unconsumed result
//  out_ready    in   1      consumer accepts when out_valid & out_ready
//  out_data     out  OUT_W  decoded rate estimate
//  window_done  out  1      1-cycle pulse when a window result is loaded
//  overrun      out  1      sticky: an unconsumed result was overwritten
// BEHAVIOUR
//  - Interface: one clock; reset is asynchronous and active-low.
//  - Reset (rst=0), immediate: out_valid=0, out_data=0, window_done=0, overrun=0,
//    internal window index=0, spike count=0. Reset mid-window discards the partial window.
//  - Counter widths: CNT_W=$clog2(WINDOW*N_CH+1); window index $clog2(WINDOW) bits.
//  - COUNT (enable=1, clear=0): count += popcount(spike_in).
//    - The index increments each cycle.
//    - On index==WINDOW-1 the cycle's spikes are included.
//    - The result is formed, then index and count restart at 0 on the next edge.
//    - No dead cycle between windows.
//  - enable=0: index, count and buffer contents freeze; the handshake still operates.
//  - Scaling: raw = count << (OUT_W - log2(WINDOW*N_CH)).
//    - count==WINDOW*N_CH saturates raw to all-ones (0xFFFF).
//    - Pure shift, no divider.
//  - Load: at the edge ending the window, out_data <= result, out_valid <= 1,
//    window_done pulses for exactly that cycle.
//    - Latency: out_valid rises 1 cycle after the last window cycle's edge.
//  - Handshake: out_valid & out_ready at an edge consumes the result, out_valid <= 0.
//    - out_data holds its value after consumption.
//  - Simultaneous load and consume at the same edge: the new result loads,
//    out_valid stays 1, and no overrun is raised.
//  - Load while out_valid=1 and not consumed: overwrite out_data, set overrun (sticky).
//  - clear=1, priority over enable: index=0, count=0, out_valid=0, overrun=0,
//    window_done=0. out_data keeps its value, except the EMA state is zeroed
//    (see CONFIGURATION).
//  - out_valid never depends combinationally on out_ready.
// CONFIGURATION
//  SPIKE_DEC_SMOOTH_EN defined:
//  - result = ema + ((raw - ema) >>> ALPHA_SH), computed signed at OUT_W+1 bits.
//  - The ema register updates only at a window end. out_data = ema.
//  - ema resets to 0; clear zeroes ema and out_data.
//  SPIKE_DEC_SMOOTH_EN undefined:
//  - result = raw. No ema register is built.
// TESTING
//  (defaults N_CH=1, WINDOW=32, OUT_W=16)
//  1. rst low mid-window with spikes -> all outputs 0 immediately; the first window
//     after release counts from 0.
//  2. spike_in=1 for 32 enabled cycles, out_ready=1 -> window_done pulse,
//     out_data=0xFFFF (saturated), out_valid high 1 cycle then consumed.
//  3. spike every other cycle (16/32) -> out_data=0x8000; 1 spike -> 0x0800;
//     0 spikes -> 0x0000 with out_valid still asserted.
//  4. out_ready=0 across two windows (16, then 8 spikes) -> overrun=1, out_data=0x4000;
//     clear -> overrun=0, out_valid=0.
//  5. enable=0 for 10 cycles mid-window -> result identical to the uninterrupted
//     16-spike window (0x8000), delayed by 10 cycles.
//  6. out_ready=1 on the window-end edge with out_valid=1 -> new data loads,
//     out_valid stays 1, overrun stays 0.
//  SMOOTH_EN, ALPHA_SH=2, constant 32/32 windows -> out_data 0x3FFF, then 0x6FFF,
//  then 0x93FF.

Source files
------------

// File: rtl/spike_rate_decoder.sv
//------------------------------------------------------------------------------
// Module      : spike_rate_decoder
// Description : Counts spikes over a fixed window of enabled cycles and scales
//               the count to a 0..2^OUT_W-1 rate estimate, offered through a
//               1-deep valid/ready output buffer with a sticky overrun flag.
//               Optional macro SPIKE_DEC_SMOOTH_EN adds an EMA smoother
//               (shift ALPHA_SH) on the window results.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module spike_rate_decoder #(
  parameter int N_CH     = 1,
  parameter int WINDOW   = 32,
  parameter int OUT_W    = 16,
  parameter int ALPHA_SH = 2
) (
  input  logic             clk,
  input  logic             rst,          // asynchronous, active-low
  input  logic             enable,
  input  logic             clear,
  input  logic [N_CH-1:0]  spike_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             window_done,
  output logic             overrun
);

  localparam int c_TOTAL = WINDOW * N_CH;
  localparam int c_CNT_W = $clog2(c_TOTAL + 1);
  localparam int c_IDX_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int c_LOG2  = $clog2(c_TOTAL);
  localparam int c_SH    = OUT_W - c_LOG2;

  // Elaboration-time guards on the parameter set
  if ((c_TOTAL & (c_TOTAL - 1)) != 0 || c_TOTAL > 65536 || c_SH < 0) begin : g_bad_window
    $error("spike_rate_decoder: WINDOW*N_CH must be a power of two <= 2^OUT_W");
  end
  if (ALPHA_SH < 1 || ALPHA_SH > 8) begin : g_bad_alpha
    $error("spike_rate_decoder: ALPHA_SH must be in 1..8");
  end

  logic [c_IDX_W-1:0] r_idx;
  logic [c_CNT_W-1:0] r_cnt;
  logic [OUT_W-1:0]   r_data;
  logic               r_valid;
  logic               r_done;
  logic               r_overrun;

  logic [c_CNT_W-1:0] w_pop;
  logic [c_CNT_W-1:0] w_cnt_next;
  logic               w_last;
  logic [OUT_W-1:0]   w_raw;
  logic [OUT_W-1:0]   w_result;
  logic               w_consume;

  // Number of spike lines active this cycle
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_pop = w_pop + c_CNT_W'(spike_in[i]);
    end
  end

  assign w_cnt_next = r_cnt + w_pop;
  assign w_last     = (r_idx == c_IDX_W'(WINDOW - 1));
  assign w_consume  = r_valid & out_ready;

  // A full window cannot be represented after the shift, so it saturates
  assign w_raw = (w_cnt_next == c_CNT_W'(c_TOTAL)) ? {OUT_W{1'b1}}
                                                   : (OUT_W'(w_cnt_next) << c_SH);

`ifdef SPIKE_DEC_SMOOTH_EN
  logic signed [OUT_W:0] w_diff;
  logic signed [OUT_W:0] w_step;
  logic signed [OUT_W:0] w_sum;

  // EMA step toward the new raw value; r_data doubles as the ema state
  always_comb begin
    w_diff   = $signed({1'b0, w_raw}) - $signed({1'b0, r_data});
    w_step   = w_diff >>> ALPHA_SH;
    w_sum    = $signed({1'b0, r_data}) + w_step;
    w_result = w_sum[OUT_W-1:0];
  end
`else
  assign w_result = w_raw;
`endif

  // Window counting, result load, handshake and overrun tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx     <= '0;
      r_cnt     <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else if (clear) begin
      r_idx     <= '0;
      r_cnt     <= '0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
`ifdef SPIKE_DEC_SMOOTH_EN
      r_data    <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      if (enable && w_last) begin
        // Window ends: load the result; a same-edge consume frees the slot
        r_idx   <= '0;
        r_cnt   <= '0;
        r_data  <= w_result;
        r_valid <= 1'b1;
        r_done  <= 1'b1;
        if (r_valid && !out_ready) begin
          r_overrun <= 1'b1;
        end
      end else begin
        if (enable) begin
          r_idx <= r_idx + c_IDX_W'(1);
          r_cnt <= w_cnt_next;
        end
        if (w_consume) begin
          r_valid <= 1'b0;
        end
      end
    end
  end

  assign out_valid   = r_valid;
  assign out_data    = r_data;
  assign window_done = r_done;
  assign overrun     = r_overrun;

endmodule

`default_nettype wire
